hilo_muldiv_unit: RTL and testbench
===================================

// Module: hilo_muldiv_unit
// PURPOSE
//  Parametrised HI/LO multiply/divide unit for the EXE stage; replaces vendor mul/div IP.
//  Executes MULT/MULTU/DIV/DIVU/MADD/MADDU/MSUB/MSUBU/MTHI/MTLO/MFHI/MFLO.
//  Holds architectural HI/LO. Multiply latency is configurable; divide is an iterative radix-2 divider.
//  Supports pipeline flush and exception write-suppress.
// PARAMETERS
//  DATA_W   32  operand / HI / LO width (>=8, even)
//  MUL_LAT  2   cycles from op acceptance to mult result (>=1)
// PORTS
//  clk           in   1         clock
//  reset         in   1         synchronous, active-high
//  op_valid      in   1         EXE holds op/src1/src2 stable until done or flush
//  hi_lo_op      in   12        one-hot: [0]div [1]divu [2]mult [3]multu [4]mthi [5]mtlo
//                               [6]mfhi [7]mflo [8]madd [9]maddu [10]msub [11]msubu
//  src1          in   DATA_W    rs operand
//  src2          in   DATA_W    rt operand
//  flush         in   1         abort the in-flight op; no HI/LO update
//  wr_disable    in   1         suppress the HI/LO write in the done cycle (exception in MEM)
//  done          out  1         result valid this cycle; EXE may advance
//  hi_lo_result  out  DATA_W    result for the writeback path
//  busy          out  1         FSM not in IDLE
// BEHAVIOUR
//  Reset: FSM=IDLE, HI=LO=0, busy=0, counters=0; done is 0 unless op_valid carries a 1-cycle op.
//  FSM states: IDLE, MUL, DIV, DONE.
//  - Cycle 0: first op_valid cycle in IDLE. Operands and op are latched on this edge.
//  - mthi/mtlo/mfhi/mflo, or op_valid with no op bit set: done is combinational in cycle 0.
//    FSM stays IDLE; HI/LO write (if any) happens on that edge.
//  - mult/multu: IDLE->MUL; done in cycle MUL_LAT.
//    Signed ops use abs-value multiply plus a sign fix; the 2*DATA_W product is exact.
//  - madd*/msub*: {HI,LO} +/- product, computed modulo 2^(2*DATA_W); done in cycle MUL_LAT+1.
//  - div/divu: IDLE->DIV. Cycle 0 latches abs values. Cycles 1..DATA_W each retire one quotient bit.
//    DIV->DONE; done in cycle DATA_W+1 with the sign fix applied.
//    Quotient takes the sign of src1^src2; remainder takes the sign of src1.
//  - DONE->IDLE unconditionally next cycle. done is high exactly 1 cycle per op.
//    The next op may be accepted in the cycle after DONE.
//  Writes: LO=quotient, HI=remainder (div); {HI,LO}=product/accumulate (mul family);
//    src1 goes to HI (mthi) or LO (mtlo).
//  - Writes commit on the done edge only when wr_disable=0 and flush=0.
//  hi_lo_result: mfhi->HI; mflo->LO; div*->quotient; mul family->new LO; mthi/mtlo->src1.
//  - Outside done cycles the value is don't-care.
//  - mfhi/mflo read the register value, so a read in the cycle after a write sees the new value.
//  Divide by zero: quotient = all ones, remainder = src1; latency unchanged.
//  Signed overflow (MIN / -1): quotient = MIN, remainder = 0.
//  flush in any state: FSM->IDLE next edge, no write, done=0 that cycle.
//    flush has priority over completion in the same cycle.
//  op changes while busy: protocol violation. The latched op is used; assertion fires in sim.
//  Reset mid-operation: immediate return to reset state; HI/LO cleared.
// TESTING
//  1 mult: src1=0xFFFFFFFE, src2=3 -> done @cycle 2; HI=0xFFFFFFFF, LO=0xFFFFFFFA, result=0xFFFFFFFA.
//  2 multu: src1=0xFFFFFFFF, src2=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
//  3 div: src1=-7, src2=2 -> done @cycle 33; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//    divu 7/0 -> LO=0xFFFFFFFF, HI=7.
//  4 madd: HI:LO=0:0xFFFFFFFF, src1=1, src2=1 -> HI=1, LO=0, done @cycle 3.
//    msubu from 0 with 1*1 -> HI=LO=0xFFFFFFFF.
//  5 flush: div started, flush @cycle 10 -> done never pulses, HI/LO unchanged, busy=0 @cycle 11.
//    The next mtlo completes in 1 cycle.
//  6 wr_disable=1 in the done cycle of mult 5*5 -> done=1, result=25, HI/LO unchanged.
//    Then mthi 0xA5A5A5A5 -> next-cycle mfhi returns 0xA5A5A5A5.

Source files
------------

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
//   HI/LO multiply/divide unit for the EXE stage. Holds the architectural
//   HI and LO registers and executes MULT/MULTU/DIV/DIVU/MADD/MADDU/MSUB/
//   MSUBU/MTHI/MTLO/MFHI/MFLO. Multiplies complete after a configurable
//   latency; divides use an iterative radix-2 restoring divider that retires
//   one quotient bit per cycle.
//
// Parameters
//   DATA_W   operand / HI / LO width (>= 8, even)
//   MUL_LAT  cycles from op acceptance to multiply result (>= 1)
//
// Ports
//   clk           clock
//   reset         synchronous, active-high reset
//   op_valid      op/src1/src2 are valid and held stable until done or flush
//   hi_lo_op      one-hot op: [0]div [1]divu [2]mult [3]multu [4]mthi
//                 [5]mtlo [6]mfhi [7]mflo [8]madd [9]maddu [10]msub [11]msubu
//   src1, src2    rs / rt operands
//   flush         abort the in-flight op, no HI/LO update
//   wr_disable    suppress the HI/LO write in the done cycle
//   done          result valid this cycle
//   hi_lo_result  result for the writeback path (valid only while done)
//   busy          FSM is not idle
module hilo_muldiv_unit #(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  input  logic [11:0]       hi_lo_op,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic              flush,
  input  logic              wr_disable,
  output logic              done,
  output logic [DATA_W-1:0] hi_lo_result,
  output logic              busy
);

  localparam int CNT_MAX = (DATA_W > MUL_LAT + 1) ? DATA_W : MUL_LAT + 1;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] hi_q, lo_q;
  logic [CNT_W-1:0]  cnt;
  logic [11:0]       op_r;
  // op_a holds |src1|; during a divide it shifts left and collects quotient bits.
  logic [DATA_W-1:0] op_a, op_b;
  logic [DATA_W-1:0] div_r;
  logic [DATA_W-1:0] src1_r;
  logic              q_neg, r_neg, div_zero;

  logic in_div, in_mul, in_signed, accept;
  logic hi_we, lo_we;
  logic [DATA_W-1:0] hi_nxt, lo_nxt;

  logic [CNT_W-1:0]    mul_target;
  logic                is_acc, is_sub;
  logic [2*DATA_W-1:0] prod_abs, prod, acc, mul_out;

  logic [DATA_W:0]   r_shift, r_diff;
  logic              q_bit;
  logic [DATA_W-1:0] quo, rem;

  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] x, input logic sgn);
    return (sgn && x[DATA_W-1]) ? -x : x;
  endfunction

  assign in_div    = hi_lo_op[0] | hi_lo_op[1];
  assign in_mul    = hi_lo_op[2] | hi_lo_op[3] | (|hi_lo_op[11:8]);
  assign in_signed = hi_lo_op[0] | hi_lo_op[2] | hi_lo_op[8] | hi_lo_op[10];
  assign accept    = (state == IDLE) && op_valid && !flush;
  assign busy      = (state != IDLE);

  // Multiply datapath works on magnitudes; the sign is restored afterwards so
  // the full 2*DATA_W product stays exact, including MIN*MIN.
  assign is_acc     = |op_r[11:8];
  assign is_sub     = op_r[10] | op_r[11];
  assign mul_target = is_acc ? CNT_W'(MUL_LAT + 1) : CNT_W'(MUL_LAT);
  assign prod_abs   = {{DATA_W{1'b0}}, op_a} * {{DATA_W{1'b0}}, op_b};
  assign prod       = q_neg ? -prod_abs : prod_abs;
  assign acc        = {hi_q, lo_q};
  assign mul_out    = is_acc ? (is_sub ? acc - prod : acc + prod) : prod;

  // One restoring step. The partial remainder is always below the divisor,
  // so the borrow out of the subtraction is a valid "remainder < divisor" flag.
  assign r_shift = {div_r, op_a[DATA_W-1]};
  assign r_diff  = r_shift - {1'b0, op_b};
  assign q_bit   = ~r_diff[DATA_W];

  // Divide-by-zero bypasses the sign fix; MIN / -1 falls out naturally as
  // quotient MIN, remainder 0.
  assign quo = div_zero ? {DATA_W{1'b1}} : (q_neg ? -op_a : op_a);
  assign rem = div_zero ? src1_r : (r_neg ? -div_r : div_r);

  always_comb begin
    state_nxt    = state;
    done         = 1'b0;
    hi_we        = 1'b0;
    lo_we        = 1'b0;
    hi_nxt       = hi_q;
    lo_nxt       = lo_q;
    hi_lo_result = '0;
    unique case (state)
      IDLE: begin
        if (op_valid && !flush) begin
          if (in_div) begin
            state_nxt = DIV;
          end else if (in_mul) begin
            state_nxt = MUL;
          end else begin
            done = 1'b1;
            if (hi_lo_op[4]) begin
              hi_we  = 1'b1;
              hi_nxt = src1;
            end
            if (hi_lo_op[5]) begin
              lo_we  = 1'b1;
              lo_nxt = src1;
            end
            if (hi_lo_op[6])
              hi_lo_result = hi_q;
            else if (hi_lo_op[7])
              hi_lo_result = lo_q;
            else
              hi_lo_result = src1;
          end
        end
      end
      MUL: begin
        if (flush) begin
          state_nxt = IDLE;
        end else if (cnt == mul_target) begin
          state_nxt    = IDLE;
          done         = 1'b1;
          hi_we        = 1'b1;
          lo_we        = 1'b1;
          hi_nxt       = mul_out[2*DATA_W-1:DATA_W];
          lo_nxt       = mul_out[DATA_W-1:0];
          hi_lo_result = mul_out[DATA_W-1:0];
        end
      end
      DIV: begin
        if (flush)
          state_nxt = IDLE;
        else if (cnt == CNT_W'(DATA_W))
          state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
        if (!flush) begin
          done         = 1'b1;
          hi_we        = 1'b1;
          lo_we        = 1'b1;
          hi_nxt       = rem;
          lo_nxt       = quo;
          hi_lo_result = quo;
        end
      end
    endcase
    if (wr_disable) begin
      hi_we = 1'b0;
      lo_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt      <= '0;
      op_r     <= '0;
      op_a     <= '0;
      op_b     <= '0;
      div_r    <= '0;
      src1_r   <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      if (hi_we) hi_q <= hi_nxt;
      if (lo_we) lo_q <= lo_nxt;

      if (accept) begin
        op_r     <= hi_lo_op;
        op_a     <= abs_val(src1, in_signed);
        op_b     <= abs_val(src2, in_signed);
        div_r    <= '0;
        src1_r   <= src1;
        q_neg    <= in_signed & (src1[DATA_W-1] ^ src2[DATA_W-1]);
        r_neg    <= in_signed & src1[DATA_W-1];
        div_zero <= (src2 == '0);
      end else if (state == DIV && !flush) begin
        op_a  <= {op_a[DATA_W-2:0], q_bit};
        div_r <= q_bit ? r_diff[DATA_W-1:0] : r_shift[DATA_W-1:0];
      end

      // cnt equals the cycle number relative to acceptance while MUL/DIV run.
      if (state == IDLE)
        cnt <= (accept && (in_div || in_mul)) ? CNT_W'(1) : '0;
      else if (state_nxt == IDLE || state_nxt == DONE)
        cnt <= '0;
      else
        cnt <= cnt + CNT_W'(1);
    end
  end

  op_stable_a: assert property (@(posedge clk) disable iff (reset)
    (busy && op_valid) |-> (hi_lo_op == op_r));

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit
//   Self-checking bench for hilo_muldiv_unit (DATA_W=32, MUL_LAT=2).
//   Table of directed vectors (preload HI/LO, run one op, check latency,
//   result and the resulting HI/LO), plus hand-written sequences for reset,
//   flush and reset in the middle of a divide.
module tb_hilo_muldiv_unit;

  localparam int W = 32;

  localparam logic [11:0] OP_DIV   = 12'h001;
  localparam logic [11:0] OP_DIVU  = 12'h002;
  localparam logic [11:0] OP_MULT  = 12'h004;
  localparam logic [11:0] OP_MULTU = 12'h008;
  localparam logic [11:0] OP_MTHI  = 12'h010;
  localparam logic [11:0] OP_MTLO  = 12'h020;
  localparam logic [11:0] OP_MFHI  = 12'h040;
  localparam logic [11:0] OP_MFLO  = 12'h080;
  localparam logic [11:0] OP_MADD  = 12'h100;
  localparam logic [11:0] OP_MADDU = 12'h200;
  localparam logic [11:0] OP_MSUB  = 12'h400;
  localparam logic [11:0] OP_MSUBU = 12'h800;

  logic         clk = 1'b0;
  logic         reset;
  logic         op_valid;
  logic [11:0]  hi_lo_op;
  logic [W-1:0] src1, src2;
  logic         flush;
  logic         wr_disable;
  logic         done;
  logic [W-1:0] hi_lo_result;
  logic         busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hilo_muldiv_unit #(.DATA_W(W), .MUL_LAT(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .op_valid     (op_valid),
    .hi_lo_op     (hi_lo_op),
    .src1         (src1),
    .src2         (src2),
    .flush        (flush),
    .wr_disable   (wr_disable),
    .done         (done),
    .hi_lo_result (hi_lo_result),
    .busy         (busy)
  );

  typedef struct {
    string        name;
    logic [11:0]  op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] pre_hi;
    logic [W-1:0] pre_lo;
    logic         wd;
    int           lat;
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs[NVEC];

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Presents one op from cycle 0 and holds it until done (bounded); lat is the
  // cycle number of the done pulse relative to cycle 0, or -1 on timeout.
  task automatic applyStimulus(input logic [11:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic wd, output int lat, output logic [W-1:0] res);
    lat = -1;
    res = '0;
    @(negedge clk);
    op_valid   = 1'b1;
    hi_lo_op   = op;
    src1       = a;
    src2       = b;
    wr_disable = wd;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (done) begin
        lat = c;
        res = hi_lo_result;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    op_valid   = 1'b0;
    hi_lo_op   = '0;
    wr_disable = 1'b0;
  endtask

  task automatic writeHiLo(input logic [W-1:0] h, input logic [W-1:0] l);
    int lat;
    logic [W-1:0] res;
    applyStimulus(OP_MTHI, h, '0, 1'b0, lat, res);
    applyStimulus(OP_MTLO, l, '0, 1'b0, lat, res);
  endtask

  task automatic readHiLo(output logic [W-1:0] h, output logic [W-1:0] l);
    int lat;
    applyStimulus(OP_MFHI, '0, '0, 1'b0, lat, h);
    applyStimulus(OP_MFLO, '0, '0, 1'b0, lat, l);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    logic [W-1:0] res, h, l;
    logic saw_done;

    vecs[0]  = '{"mult_neg",    OP_MULT,  32'hFFFFFFFE, 32'd3,        32'h0,        32'h0,        1'b0, 2,  32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1]  = '{"multu_max",   OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0,        1'b0, 2,  32'h00000001, 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{"div_neg",     OP_DIV,   32'hFFFFFFF9, 32'd2,        32'h0,        32'h0,        1'b0, 33, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{"divu_zero",   OP_DIVU,  32'd7,        32'd0,        32'h0,        32'h0,        1'b0, 33, 32'hFFFFFFFF, 32'd7,        32'hFFFFFFFF};
    vecs[4]  = '{"madd_carry",  OP_MADD,  32'd1,        32'd1,        32'h0,        32'hFFFFFFFF, 1'b0, 3,  32'h0,        32'd1,        32'h0};
    vecs[5]  = '{"msubu_wrap",  OP_MSUBU, 32'd1,        32'd1,        32'h0,        32'h0,        1'b0, 3,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[6]  = '{"mult_wrdis",  OP_MULT,  32'd5,        32'd5,        32'h11111111, 32'h22222222, 1'b1, 2,  32'd25,       32'h11111111, 32'h22222222};
    vecs[7]  = '{"div_ovf",     OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h0,        1'b0, 33, 32'h80000000, 32'h0,        32'h80000000};
    vecs[8]  = '{"div_negdvs",  OP_DIV,   32'd100,      32'hFFFFFFF9, 32'h0,        32'h0,        1'b0, 33, 32'hFFFFFFF2, 32'd2,        32'hFFFFFFF2};
    vecs[9]  = '{"div_szero",   OP_DIV,   32'hFFFFFFFB, 32'd0,        32'h0,        32'h0,        1'b0, 33, 32'hFFFFFFFF, 32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[10] = '{"msub_neg",    OP_MSUB,  32'hFFFFFFFD, 32'd4,        32'h0,        32'd10,       1'b0, 3,  32'h16,       32'h0,        32'h16};
    vecs[11] = '{"maddu_carry", OP_MADDU, 32'h10,       32'h10,       32'd1,        32'hFFFFFFF0, 1'b0, 3,  32'hF0,       32'd2,        32'hF0};
    vecs[12] = '{"divu_big",    OP_DIVU,  32'hFFFFFFFF, 32'h10,       32'h0,        32'h0,        1'b0, 33, 32'h0FFFFFFF, 32'hF,        32'h0FFFFFFF};
    vecs[13] = '{"mthi",        OP_MTHI,  32'hA5A5A5A5, 32'h0,        32'h0,        32'h0,        1'b0, 0,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0};
    vecs[14] = '{"mtlo_wrdis",  OP_MTLO,  32'h12345678, 32'h0,        32'h55,       32'h66,       1'b1, 0,  32'h12345678, 32'h55,       32'h66};
    vecs[15] = '{"mult_min",    OP_MULT,  32'h80000000, 32'h80000000, 32'h0,        32'h0,        1'b0, 2,  32'h0,        32'h40000000, 32'h0};

    reset      = 1'b1;
    op_valid   = 1'b0;
    hi_lo_op   = '0;
    src1       = '0;
    src2       = '0;
    flush      = 1'b0;
    wr_disable = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_done", {31'b0, done}, 32'd0);
    readHiLo(h, l);
    checkOutput("reset_hi", h, 32'h0);
    checkOutput("reset_lo", l, 32'h0);

    for (int i = 0; i < NVEC; i++) begin
      writeHiLo(vecs[i].pre_hi, vecs[i].pre_lo);
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].wd, lat, res);
      checkOutput($sformatf("%s_lat", vecs[i].name), lat, vecs[i].lat);
      checkOutput($sformatf("%s_res", vecs[i].name), res, vecs[i].res);
      readHiLo(h, l);
      checkOutput($sformatf("%s_hi", vecs[i].name), h, vecs[i].hi);
      checkOutput($sformatf("%s_lo", vecs[i].name), l, vecs[i].lo);
    end

    // Flush a divide in cycle 10: no done, no write, idle in cycle 11.
    writeHiLo(32'h0BADF00D, 32'hCAFEBABE);
    saw_done = 1'b0;
    @(negedge clk);
    op_valid = 1'b1;
    hi_lo_op = OP_DIV;
    src1     = 32'd100;
    src2     = 32'd3;
    for (int c = 0; c <= 10; c++) begin
      if (c == 10) flush = 1'b1;
      #1;
      if (done) saw_done = 1'b1;
      if (c == 1) checkOutput("flush_busy_mid", {31'b0, busy}, 32'd1);
      @(negedge clk);
    end
    flush    = 1'b0;
    op_valid = 1'b0;
    hi_lo_op = '0;
    #1;
    checkOutput("flush_busy_after", {31'b0, busy}, 32'd0);
    checkOutput("flush_no_done", {31'b0, saw_done}, 32'd0);
    applyStimulus(OP_MTLO, 32'h600DCAFE, '0, 1'b0, lat, res);
    checkOutput("flush_mtlo_lat", lat, 32'd0);
    readHiLo(h, l);
    checkOutput("flush_hi", h, 32'h0BADF00D);
    checkOutput("flush_lo", l, 32'h600DCAFE);

    // Reset in the middle of a divide clears HI/LO and returns to idle.
    writeHiLo(32'hDEADBEEF, 32'h01234567);
    @(negedge clk);
    op_valid = 1'b1;
    hi_lo_op = OP_DIVU;
    src1     = 32'd1000;
    src2     = 32'd7;
    repeat (5) @(negedge clk);
    #1;
    checkOutput("rst_mid_busy_before", {31'b0, busy}, 32'd1);
    reset    = 1'b1;
    op_valid = 1'b0;
    hi_lo_op = '0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rst_mid_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_mid_done", {31'b0, done}, 32'd0);
    readHiLo(h, l);
    checkOutput("rst_mid_hi", h, 32'h0);
    checkOutput("rst_mid_lo", l, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
